// File: rtl/bitwise_reduce_unit.sv
// bitwise_reduce_unit: folds COUNT operands into one WIDTH-bit AND/OR/XOR/NOR result
// over valid/ready handshakes. All outputs are registered or decoded from state.
module bitwise_reduce_unit #(
    parameter int WIDTH   = 32,
    parameter int MAX_OPS = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             error_o
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam logic [1:0] OP_AND = 2'b00, OP_XOR = 2'b10, OP_NOR = 2'b11;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, out_q, out_d, folded;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       op_q, op_d;
    logic             err_q, err_d;
    // NOR accumulates as OR; the inversion is applied once on the final value
    assign folded = op_q == OP_AND ? acc_q & in_data_i :
                    op_q == OP_XOR ? acc_q ^ in_data_i : acc_q | in_data_i;
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        op_d    = op_q;
        out_d   = out_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                if (count_i == '0 || count_i > CNT_W'(MAX_OPS)) err_d = 1'b1;
                else begin
                    op_d    = op_i;
                    rem_d   = count_i;
                    acc_d   = op_i == OP_AND ? '1 : '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: if (in_valid_i) begin
                acc_d = folded;
                rem_d = rem_q - 1'b1;
                if (rem_q == CNT_W'(1)) begin
                    out_d   = op_q == OP_NOR ? ~folded : folded;
                    state_d = DONE;
                end
            end
            DONE: if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            out_q   <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end
    assign in_ready_o  = state_q == ACCUM;
    assign out_valid_o = state_q == DONE;
    assign busy_o      = state_q != IDLE;
    assign error_o     = err_q;
    assign out_data_o  = out_q;
endmodule

// File: tb/tb_bitwise_reduce_unit.sv
// tb_bitwise_reduce_unit: directed plan plus random reductions against a behavioural model.
module tb_bitwise_reduce_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [4:0]  count_i = 5'd0;
    logic [31:0] in_data_i = 32'h0;
    logic        in_ready_o, out_valid_o, busy_o, error_o;
    logic [31:0] out_data_o;
    int checks = 0, errors = 0;

    bitwise_reduce_unit #(.WIDTH(32), .MAX_OPS(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .count_i(count_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] q[$]);
        logic [31:0] r = (op == 2'b00) ? 32'hFFFF_FFFF : 32'h0;
        foreach (q[k]) begin
            if (op == 2'b00) r = r & q[k];
            else if (op == 2'b10) r = r ^ q[k];
            else r = r | q[k];
        end
        return (op == 2'b11) ? ~r : r;
    endfunction

    task automatic run(input logic [1:0] op, input logic [31:0] q[$], input int gap_max, input int hold);
        logic [31:0] exp = model(op, q);
        start_i = 1'b1; op_i = op; count_i = 5'(q.size());
        tick();
        start_i = 1'b0; op_i = ~op; count_i = 5'd0;
        check("start_busy", busy_o, 1);
        check("start_in_ready", in_ready_o, 1);
        foreach (q[k]) begin
            int gap = $urandom_range(gap_max, 0);
            for (int g = 0; g < gap; g++) begin
                in_valid_i = 1'b0; in_data_i = $urandom;
                tick();
                check("gap_no_out_valid", out_valid_o, 0);
            end
            in_valid_i = 1'b1; in_data_i = q[k];
            tick();
            if (k < q.size() - 1) check("mid_no_out_valid", out_valid_o, 0);
        end
        in_valid_i = 1'b0; in_data_i = $urandom;
        check("done_out_valid", out_valid_o, 1);
        check("done_out_data", out_data_o, exp);
        check("done_in_ready", in_ready_o, 0);
        check("done_busy", busy_o, 1);
        for (int h = 0; h < hold; h++) begin
            start_i = 1'b1; count_i = 5'd3;
            tick();
            check("hold_out_data", out_data_o, exp);
            check("hold_out_valid", out_valid_o, 1);
            check("hold_no_error", error_o, 0);
        end
        out_ready_i = 1'b1; start_i = 1'b1; count_i = 5'd2;
        tick();
        out_ready_i = 1'b0; start_i = 1'b0;
        check("consumed_out_valid", out_valid_o, 0);
        check("consumed_busy", busy_o, 0);
        tick();
        check("idle_after_consume", busy_o, 0);
    endtask

    initial begin
        logic [31:0] q[$];
        #2;
        check("reset_busy", busy_o, 0);
        check("reset_out_data", out_data_o, 0);
        check("reset_out_valid", out_valid_o, 0);
        rst_n = 1'b1;
        tick();
        check("post_reset_error", error_o, 0);
        q = '{32'h0000000F, 32'h000000F0, 32'h0F000000};
        run(2'b01, q, 0, 0);
        check("or_value", out_data_o, 32'h0F0000FF);
        q = '{32'hFFFF0000, 32'h0F0FFFFF};
        run(2'b00, q, 3, 1);
        check("and_value", out_data_o, 32'h0F0F0000);
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(i[0] ? 32'h55555555 : 32'hAAAAAAAA);
        run(2'b10, q, 0, 0);
        check("xor16_value", out_data_o, 32'h0);
        q = '{32'h12345678};
        run(2'b10, q, 0, 0);
        check("xor1_value", out_data_o, 32'h12345678);
        q = '{32'h0, 32'h1};
        run(2'b11, q, 0, 5);
        check("nor_value", out_data_o, 32'hFFFFFFFE);
        foreach (q[k]) begin end
        for (int c = 0; c < 2; c++) begin
            start_i = 1'b1; count_i = c ? 5'd17 : 5'd0;
            tick();
            start_i = 1'b0;
            check("err_pulse", error_o, 1);
            check("err_busy", busy_o, 0);
            check("err_in_ready", in_ready_o, 0);
            tick();
            check("err_one_cycle", error_o, 0);
        end
        start_i = 1'b1; op_i = 2'b01; count_i = 5'd4;
        tick();
        start_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'hFFFF0000;
        tick();
        in_data_i = 32'h0000FFFF;
        tick();
        in_valid_i = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("async_busy", busy_o, 0);
        check("async_in_ready", in_ready_o, 0);
        check("async_out_data", out_data_o, 0);
        #3 rst_n = 1'b1;
        tick();
        check("release_no_error", error_o, 0);
        check("release_out_valid", out_valid_o, 0);
        q = '{32'hDEADBEEF};
        run(2'b01, q, 0, 0);
        check("post_abort_value", out_data_o, 32'hDEADBEEF);
        for (int t = 0; t < 30; t++) begin
            int n = $urandom_range(16, 1);
            q = {};
            for (int i = 0; i < n; i++) q.push_back($urandom);
            run(2'($urandom_range(3, 0)), q, 2, $urandom_range(3, 0));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bitwise_reduce_unit.md
Name: bitwise_reduce_unit

Overview:
Parametrised, multi-cycle bitwise logic engine for the ALU/datapath. It folds a stream of COUNT operands into one WIDTH-bit result using a selectable operation: AND, OR, XOR or NOR. Operands arrive one per cycle over a valid/ready handshake, and the result is held on a valid/ready output. Typical uses are mask building, parity words and flag merging over register groups.

Parameters:
WIDTH, 32, operand and result width in bits
MAX_OPS, 16, maximum operands per reduction
CNT_W, 5, width of count input; must satisfy 2^CNT_W > MAX_OPS

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
start  input  1  request a new reduction; sampled only in IDLE
op  input  2  00 AND, 01 OR, 10 XOR, 11 NOR; latched on accepted start
count  input  CNT_W  number of operands; latched on accepted start
in_valid  input  1  in_data carries an operand
in_data  input  WIDTH  operand
in_ready  output  1  unit accepts an operand this cycle
out_valid  output  1  result available
out_data  output  WIDTH  result
out_ready  input  1  consumer takes result
busy  output  1  high in ACCUM or DONE
error  output  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE.
  - in_ready, out_valid, busy and error are 0.
  - out_data, the accumulator, the remaining counter and the latched op are 0.
  - Any partial reduction is discarded. No output pulse occurs on release.
- All outputs are registered or decoded from registered state. No combinational path from any input to any output.
- State machine: IDLE -> ACCUM -> DONE -> IDLE.
- IDLE:
  - busy=0, in_ready=0, out_valid=0.
  - start=1 with count==0 or count>MAX_OPS: error=1 on the next cycle for exactly one cycle; stay in IDLE.
  - start=1 with a valid count:
    - Latch op and count; remaining <= count.
    - Accumulator <= identity: all-ones for AND, all-zeros for OR, XOR and NOR.
    - Go to ACCUM.
- ACCUM:
  - busy=1, in_ready=1.
  - A beat is accepted on in_valid & in_ready.
  - Per beat: AND -> acc & in_data; XOR -> acc ^ in_data; OR and NOR -> acc | in_data. Then remaining decrements.
  - in_valid=0 stalls with no state change. Gaps of any length are legal.
  - Beat accepted while remaining==1: go to DONE next cycle. out_data <= final value, inverted bitwise when op==NOR.
  - Throughput is one operand per cycle.
- DONE:
  - busy=1, in_ready=0, out_valid=1.
  - out_data stays stable until out_valid & out_ready, then go to IDLE the next cycle.
  - out_ready may already be high on the first DONE cycle; the result is then consumed in one cycle.
- Latency: out_valid rises on the clock edge after the last operand is accepted.
- After leaving DONE, out_data holds the last result; it is meaningful only while out_valid=1.
- start outside IDLE is ignored: no error, no effect. start in the same cycle a result is consumed is also ignored. The next start is honoured once in IDLE.
- op and count changes outside an accepted start have no effect on a running reduction.
- count==1: result equals the single operand, inverted for NOR.
- Width: all logic is bit-parallel over WIDTH. No carries and no cross-bit interaction.

Test Plan:
1. OR, count=3, operands 0x0000000F, 0x000000F0, 0x0F000000 on consecutive cycles -> out_valid on the edge after the 3rd beat; out_data=0x0F0000FF; busy=1 from the start edge until the result is consumed.
2. AND, count=2, operands 0xFFFF0000 then 0x0F0FFFFF, with in_valid low for 3 cycles between them -> no premature out_valid; out_data=0x0F0F0000.
3. XOR, count=16 (MAX_OPS), alternating 0xAAAAAAAA / 0x55555555 -> out_data=0x00000000. Then XOR, count=1, operand 0x12345678 -> out_data=0x12345678.
4. NOR, count=2, operands 0x00000000, 0x00000001, out_ready held low 5 cycles -> out_valid=1 and out_data=0xFFFFFFFE stable, in_ready=0, start pulses ignored. out_ready=1 -> IDLE next cycle.
5. start with count=0, then start with count=17 -> error pulses exactly one cycle each; busy stays 0; in_ready stays 0.
6. OR, count=4, reset driven low after 2 accepted beats -> all outputs 0 immediately, asynchronously. After release, OR count=1 operand 0xDEADBEEF -> out_data=0xDEADBEEF with no residue from the aborted run.
